// File: rtl/addsub_accumulator.sv
// Registered two's-complement add/sub accumulator. Commands arrive over a valid/ready
// handshake, are executed in one cycle and the result is held until the consumer takes it.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a command, in_ready=1
// S_EXEC | captured command is applied to the accumulator (one cycle)
// S_RESP | result presented with out_valid=1 until out_ready
module addsub_accumulator #(
   parameter int WIDTH    = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc,
   output logic             cout,
   output logic             v,
   output logic             v_sticky,
   output logic [7:0]       op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             cout_q, cout_d;
   logic             v_q, v_d;
   logic             v_sticky_q, v_sticky_d;
   logic [7:0]       op_count_q, op_count_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;

   logic             is_sub;
   logic [WIDTH-1:0] y_eff;
   logic [WIDTH:0]   sum_full;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;
   logic [WIDTH-1:0] sat_val;

   // SUB is x + ~y + 1, so cout=1 means no borrow
   always_comb begin
      is_sub   = (op_q == OP_SUB);
      y_eff    = is_sub ? ~operand_q : operand_q;
      sum_full = {1'b0, acc_q} + {1'b0, y_eff} + {{WIDTH{1'b0}}, is_sub};
      sum      = sum_full[WIDTH-1:0];
      carry    = sum_full[WIDTH];
      ovf      = (acc_q[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
      sat_val  = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      operand_d   = operand_q;
      acc_d       = acc_q;
      cout_d      = cout_q;
      v_d         = v_q;
      v_sticky_d  = v_sticky_q;
      op_count_d  = op_count_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               op_d       = op;
               operand_d  = operand;
               op_count_d = op_count_q + 8'd1;
               in_ready_d = 1'b0;
               state_d    = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_LOAD: begin
                  acc_d  = operand_q;
                  cout_d = 1'b0;
                  v_d    = 1'b0;
               end
               OP_CLEAR: begin
                  acc_d      = '0;
                  cout_d     = 1'b0;
                  v_d        = 1'b0;
                  v_sticky_d = 1'b0;
               end
               default: begin
                  // flags report the raw operation even when the result is clamped
                  acc_d      = (SATURATE && ovf) ? sat_val : sum;
                  cout_d     = carry;
                  v_d        = ovf;
                  v_sticky_d = v_sticky_q | ovf;
               end
            endcase
            out_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LOAD;
         operand_q   <= '0;
         acc_q       <= '0;
         cout_q      <= 1'b0;
         v_q         <= 1'b0;
         v_sticky_q  <= 1'b0;
         op_count_q  <= 8'd0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         operand_q   <= operand_d;
         acc_q       <= acc_d;
         cout_q      <= cout_d;
         v_q         <= v_d;
         v_sticky_q  <= v_sticky_d;
         op_count_q  <= op_count_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign acc       = acc_q;
   assign cout      = cout_q;
   assign v         = v_q;
   assign v_sticky  = v_sticky_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Drives a wrapping and a saturating accumulator with the same commands and compares
// both against an integer-arithmetic reference.
module tb_addsub_accumulator;

   localparam int C_LOAD  = 0;
   localparam int C_ADD   = 1;
   localparam int C_SUB   = 2;
   localparam int C_CLEAR = 3;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic [1:0] op;
   logic [3:0] operand;

   logic       in_ready0, out_valid0, cout0, v0, v_sticky0;
   logic       in_ready1, out_valid1, cout1, v1, v_sticky1;
   logic [3:0] acc0, acc1;
   logic [7:0] op_count0, op_count1;

   int n_vec = 0;
   int n_err = 0;

   int       m_acc[2];
   bit       m_cout[2];
   bit       m_v[2];
   bit       m_vs[2];
   bit [7:0] m_cnt;

   addsub_accumulator #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .op(op), .operand(operand), .out_valid(out_valid0), .out_ready(out_ready),
      .acc(acc0), .cout(cout0), .v(v0), .v_sticky(v_sticky0), .op_count(op_count0)
   );

   addsub_accumulator #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .op(op), .operand(operand), .out_valid(out_valid1), .out_ready(out_ready),
      .acc(acc1), .cout(cout1), .v(v1), .v_sticky(v_sticky1), .op_count(op_count1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int wrap4(input int t);
      int w;
      w = t & 15;
      if (w > 7) w = w - 16;
      return w;
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < 2; s++) begin
         m_acc[s] = 0; m_cout[s] = 0; m_v[s] = 0; m_vs[s] = 0;
      end
      m_cnt = 8'd0;
   endfunction

   // Exact integer result; overflow is simply "true result outside -8..7"
   function automatic void model_apply(input int o, input int y);
      int x, t, xu, yu;
      bit c, ov;
      for (int s = 0; s < 2; s++) begin
         x  = m_acc[s];
         xu = x & 15;
         yu = y & 15;
         case (o)
            C_LOAD: begin m_acc[s] = y; m_cout[s] = 0; m_v[s] = 0; end
            C_CLEAR: begin m_acc[s] = 0; m_cout[s] = 0; m_v[s] = 0; m_vs[s] = 0; end
            default: begin
               if (o == C_ADD) begin t = x + y; c = (xu + yu) > 15; end
               else begin t = x - y; c = (xu >= yu); end
               ov = (t > 7) || (t < -8);
               if (ov && s == 1) m_acc[s] = (t > 7) ? 7 : -8;
               else m_acc[s] = wrap4(t);
               m_cout[s] = c;
               m_v[s]    = ov;
               m_vs[s]   = m_vs[s] | ov;
            end
         endcase
      end
      m_cnt = m_cnt + 8'd1;
   endfunction

   task automatic check_state(input string ctx, input logic exp_valid);
      chk({ctx, ".acc0"}, 32'(acc0), 32'(m_acc[0] & 15));
      chk({ctx, ".acc1"}, 32'(acc1), 32'(m_acc[1] & 15));
      chk({ctx, ".cout0"}, 32'(cout0), 32'(m_cout[0]));
      chk({ctx, ".cout1"}, 32'(cout1), 32'(m_cout[1]));
      chk({ctx, ".v0"}, 32'(v0), 32'(m_v[0]));
      chk({ctx, ".v1"}, 32'(v1), 32'(m_v[1]));
      chk({ctx, ".vs0"}, 32'(v_sticky0), 32'(m_vs[0]));
      chk({ctx, ".vs1"}, 32'(v_sticky1), 32'(m_vs[1]));
      chk({ctx, ".cnt0"}, 32'(op_count0), 32'(m_cnt));
      chk({ctx, ".cnt1"}, 32'(op_count1), 32'(m_cnt));
      chk({ctx, ".out_valid"}, 32'({out_valid1, out_valid0}), exp_valid ? 32'd3 : 32'd0);
   endtask

   // Issues one command; with bp=1 the task returns while the result is held in RESP
   task automatic send(input int o, input int y, input bit bp, input string ctx);
      int n;
      out_ready = !bp;
      in_valid  = 1'b1;
      op        = 2'(o);
      operand   = 4'(y);
      n = 0;
      while (!in_ready0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) begin
         chk({ctx, ".accept_timeout"}, 32'(in_ready0), 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_apply(o, y);
      chk({ctx, ".exec_out_valid"}, 32'({out_valid1, out_valid0}), 32'd0);
      chk({ctx, ".exec_in_ready"}, 32'({in_ready1, in_ready0}), 32'd0);
      @(posedge clk); #1;
      check_state(ctx, 1'b1);
      if (!bp) begin
         @(posedge clk); #1;
         chk({ctx, ".idle_out_valid"}, 32'({out_valid1, out_valid0}), 32'd0);
         chk({ctx, ".idle_in_ready"}, 32'({in_ready1, in_ready0}), 32'd3);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   ro, ry;
      logic [3:0] held0, held1;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; operand = 4'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_state("reset", 1'b0);
      chk("reset.in_ready", 32'({in_ready1, in_ready0}), 32'd3);
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(C_LOAD, 3, 0, "load3");
      send(C_ADD, 2, 0, "add2");

      send(C_LOAD, 7, 0, "load7");
      send(C_ADD, 1, 0, "add1_ovf");
      send(C_CLEAR, 0, 0, "clear");

      send(C_LOAD, -8, 0, "loadm8");
      send(C_SUB, 1, 0, "sub1_ovf");

      send(C_LOAD, -1, 0, "loadm1");
      send(C_ADD, -1, 0, "addm1");
      send(C_SUB, -2, 0, "subm2");

      // Backpressure: a new command waits while the result is held
      send(C_LOAD, 5, 1, "bp_load5");
      held0 = acc0; held1 = acc1;
      in_valid = 1'b1; op = 2'(C_ADD); operand = 4'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp.in_ready", 32'({in_ready1, in_ready0}), 32'd0);
         chk("bp.out_valid", 32'({out_valid1, out_valid0}), 32'd3);
         chk("bp.acc0", 32'(acc0), 32'(m_acc[0] & 15));
         chk("bp.acc1", 32'(acc1), 32'(m_acc[1] & 15));
         chk("bp.cnt", 32'(op_count0), 32'(m_cnt));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release.out_valid", 32'({out_valid1, out_valid0}), 32'd0);
      chk("bp_release.cnt", 32'(op_count0), 32'(m_cnt));
      send(C_ADD, 1, 0, "bp_add1");

      for (int x = -8; x <= 7; x++) begin
         for (int y = -8; y <= 7; y++) begin
            send(C_LOAD, x, 0, $sformatf("sweep_ld_%0d", x));
            send(C_ADD, y, 0, $sformatf("sweep_add_%0d_%0d", x, y));
            send(C_LOAD, x, 0, $sformatf("sweep_ld_%0d", x));
            send(C_SUB, y, 0, $sformatf("sweep_sub_%0d_%0d", x, y));
         end
      end

      for (int i = 0; i < 200; i++) begin
         ro = int'($urandom_range(0, 3));
         ry = int'($urandom_range(0, 15)) - 8;
         send(ro, ry, 0, $sformatf("rand%0d_op%0d_y%0d", i, ro, ry));
      end

      // Reset while a command is executing
      send(C_LOAD, 5, 0, "pre_rst_load5");
      in_valid = 1'b1; op = 2'(C_ADD); operand = 4'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_state("mid_exec_reset", 1'b0);
      chk("mid_exec_reset.in_ready", 32'({in_ready1, in_ready0}), 32'd3);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("post_reset.out_valid", 32'({out_valid1, out_valid0}), 32'd0);
         chk("post_reset.acc", 32'({acc1, acc0}), 32'd0);
      end
      send(C_LOAD, 3, 0, "post_rst_load3");
      send(C_ADD, 2, 0, "post_rst_add2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
- Sequential accumulator stage built around the 4-bit signed add/sub datapath.
- Accepts operand/opcode commands over a valid/ready handshake and applies each to an internal two's-complement accumulator.
- Presents the result, carry and signed-overflow flags over an output valid/ready handshake.
- Used as the register stage behind the combinational add/sub unit, for multi-step arithmetic sequences.

Parameters:
WIDTH, 4, operand and accumulator width in bits (two's complement).
SATURATE, 0, 1 = clamp the result to the most positive/negative value on signed overflow; 0 = wrap modulo 2^WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  block can accept a command
op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
operand  input  WIDTH  signed operand y
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
acc  output  WIDTH  accumulator value (registered)
cout  output  1  carry/borrow-out of the last ADD/SUB
v  output  1  signed overflow of the last ADD/SUB
v_sticky  output  1  OR of v since the last CLEAR/reset
op_count  output  8  accepted-command counter

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All flops clear immediately when rst_n=0, independent of clk.
- Reset values: acc=0, cout=0, v=0, v_sticky=0, op_count=0, out_valid=0, in_ready=1, state=IDLE.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: in_ready=1. in_valid&&in_ready captures op and operand, increments op_count (wraps 255->0), and moves to EXEC.
  - EXEC: in_ready=0. One cycle. Computes and registers the result, then moves to RESP.
  - RESP: out_valid=1, in_ready=0. acc/cout/v stay stable while out_valid=1. out_valid&&out_ready moves to IDLE, and out_valid falls next cycle.
- Latency: command accept edge -> out_valid high 2 cycles later. Throughput is one command per 3 cycles with out_ready held high.
- Arithmetic (x=acc, y=operand):
  - ADD: {cout,sum} = x + y.
  - SUB: sum = x + ~y + 1 (cin=1), cout = carry-out of that sum (1 = no borrow).
  - v = (x[MSB]==y'[MSB]) && (sum[MSB]!=x[MSB]), where y' = y for ADD and ~y for SUB.
  - SATURATE=0: acc <= sum.
  - SATURATE=1 and v=1: acc <= x[MSB] ? 100..0 : 011..1. v and cout still report the raw operation.
- LOAD: acc <= operand; cout=0, v=0; v_sticky unchanged.
- CLEAR: acc=0, cout=0, v=0, v_sticky=0.
- v_sticky: set in EXEC whenever v is computed 1. Cleared only by CLEAR or reset.
- Inputs are sampled only on the accept edge. in_valid outside IDLE is ignored, and the command is not consumed.
- out_ready=0 in RESP holds the state indefinitely with no change to any output.
- rst_n asserted in EXEC or RESP aborts the operation. The pending result is discarded and the block returns to IDLE with reset values.

Test Plan:
- Reset then LOAD 3, ADD 2 -> out_valid 2 cycles after accept; acc=5, cout=0, v=0; op_count=2.
- LOAD 7, ADD 1 (SATURATE=0) -> acc=-8 (4'b1000), v=1, v_sticky=1, cout=0. Then CLEAR -> acc=0, v_sticky=0.
- LOAD -8, SUB 1 with SATURATE=1 -> acc=-8 (clamped), v=1, cout=1. Same sequence with SATURATE=0 -> acc=7.
- LOAD -1, ADD -1 -> acc=-2, cout=1, v=0. Then SUB -2 -> acc=0, cout=1, v=0.
- Backpressure: hold out_ready=0 for 5 cycles in RESP while in_valid=1 with a new command -> in_ready=0, acc unchanged, command not consumed. Raise out_ready -> IDLE, then the new command is accepted.
- Exhaustive sweep: for all x,y in -8..7 with both ADD and SUB (LOAD x, then op y) -> acc, cout and v match the two's-complement reference model. Pulse rst_n low mid-EXEC -> immediate return to reset values, out_valid never asserts.
